// File: rtl/ucsbece154_dmem_mp.sv
// Multi-port data memory with a fixed per-bundle stall latency, in-bundle
// store-to-load forwarding in program (port) order, and sticky range errors.
module ucsbece154_dmem_mp #(
  parameter int          NPORTS      = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     req_i,
  input  logic [NPORTS-1:0]     we_i,
  input  logic [4*NPORTS-1:0]   be_i,
  input  logic [32*NPORTS-1:0]  a_i,
  input  logic [32*NPORTS-1:0]  wd_i,
  output logic [32*NPORTS-1:0]  rd_o,
  output logic                  stall_o,
  output logic [NPORTS-1:0]     err_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              stall;
  logic              any_req;
  logic              complete;
  logic [NPORTS-1:0] in_rng;
  logic [NPORTS-1:0] wr;
  logic [AW-1:0]     idx [NPORTS];
  logic [31:0]       fwd;
  logic [31:0]       mem [DEPTH_WORDS];

  assign any_req  = |req_i;
  assign stall_o  = stall & ~reset;
  assign complete = any_req & ~stall & ~reset;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req && LATENCY > 0) begin
          state_n = S_WAIT;
          cnt_n   = 4'(LATENCY - 1);
          stall   = 1'b1;
        end
      end
      S_WAIT: begin
        // A bundle whose request changed mid-wait still completes on the count.
        if (cnt == 4'd0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
          stall = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      err_o       <= '0;
      stall_cnt_o <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (complete) err_o <= err_o | (req_i & ~in_rng);
    end
  end

  // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      in_rng[k] = ({1'b0, a_i[32*k +: 32]} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, a_i[32*k +: 32]} < LIMIT);
      idx[k]    = AW'((a_i[32*k +: 32] - BASE_ADDR) >> 2);
      wr[k]     = complete & req_i[k] & we_i[k] & in_rng[k];
    end
  end

  // Each read sees only the older ports' stores of this bundle.
  always_comb begin
    rd_o = '0;
    fwd  = '0;
    for (int k = 0; k < NPORTS; k++) begin
      fwd = mem[idx[k]];
      for (int j = 0; j < k; j++) begin
        if (wr[j] && idx[j] == idx[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (be_i[4*j + b]) fwd[8*b +: 8] = wd_i[32*j + 8*b +: 8];
          end
        end
      end
      if (complete && req_i[k] && in_rng[k]) rd_o[32*k +: 32] = fwd;
    end
  end

  // Later ports are applied last, so the youngest store wins a lane collision.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NPORTS; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (wr[k] && be_i[4*k + b]) mem[idx[k]][8*b +: 8] <= wd_i[32*k + 8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ucsbece154_dmem_mp.md
UCSBECE154_DMEM_MP -- requirements
Module: ucsbece154_dmem_mp

Interface
REQ-001 The block SHALL expose parameter NPORTS, default 2, meaning the number of issue-slot memory ports; legal values are 1 to 4.
REQ-002 The block SHALL expose parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored; it is a power of 2.
REQ-003 The block SHALL expose parameter BASE_ADDR, default 32'h1000_0000, meaning the byte address of word 0.
REQ-004 The block SHALL expose parameter LATENCY, default 2, meaning the stall cycles per access bundle; legal values are 0 to 15.
REQ-005 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have req_i, input, NPORTS bits: per-port access request.
REQ-008 The block SHALL have we_i, input, NPORTS bits: per-port write enable; it is qualified by req_i.
REQ-009 The block SHALL have be_i, input, 4*NPORTS bits: per-port byte enables; bit 0 is byte [7:0].
REQ-010 The block SHALL have a_i, input, 32*NPORTS bits: per-port byte address; port k occupies bits [32k+31:32k].
REQ-011 The block SHALL have wd_i, input, 32*NPORTS bits: per-port write data.
REQ-012 The block SHALL have rd_o, output, 32*NPORTS bits: per-port read data.
REQ-013 The block SHALL have stall_o, output, 1 bit: the pipeline must hold all inputs stable while it is high.
REQ-014 The block SHALL have err_o, output, NPORTS bits: sticky per-port out-of-range flag.
REQ-015 The block SHALL have stall_cnt_o, output, 32 bits: total stall cycles since reset.

Function
REQ-016 Port index SHALL equal program order within a bundle: port 0 is oldest.
REQ-017 The FSM SHALL have two states. IDLE moves to WAIT when any req_i bit is set and LATENCY>0, loading cnt<=LATENCY-1. WAIT moves to IDLE when cnt==0; otherwise cnt decrements.
REQ-018 stall_o SHALL be 1 in IDLE when any req_i bit is set and LATENCY>0, and 1 in WAIT when cnt!=0. It SHALL be 0 otherwise.
REQ-019 The completion cycle is the cycle where stall_o==0 and some req_i bit is set. In that cycle, rd_o SHALL be valid combinationally and writes SHALL commit on the closing clock edge.
REQ-020 Each bundle SHALL take exactly LATENCY+1 cycles, with stall_o high for the first LATENCY cycles. LATENCY=0 SHALL never stall.
REQ-021 Word index SHALL be (a-BASE_ADDR)>>2. Address bits a[1:0] SHALL be ignored, so all accesses are word-aligned.
REQ-022 An access is out of range when a<BASE_ADDR or a>=BASE_ADDR+4*DEPTH_WORDS, compared in 33-bit arithmetic so there is no wrap. For such an access:
  - the write SHALL be suppressed;
  - rd_o SHALL be 0;
  - err_o[k] SHALL be set at the completion edge and held until reset.
REQ-023 Writes SHALL commit per byte lane where be_i is set. On a same-word, same-lane collision, the highest-index writing port SHALL win.
REQ-024 A read on port k SHALL return the array word merged, byte by byte and in ascending port order, with the enabled bytes of writes from ports j<k to the same word in the same bundle. Writes from ports j>=k SHALL NOT be visible to port k.
REQ-025 A port with we_i=1 SHALL still drive rd_o with its forwarded pre-write value per REQ-024.
REQ-026 rd_o[k] SHALL be 0 whenever req_i[k]==0 or stall_o==1.
REQ-027 stall_cnt_o SHALL increment by 1 on every edge where stall_o==1, and wrap from 2^32-1 to 0.
REQ-028 If req_i changes while in WAIT (a protocol violation), the block SHALL use the current inputs at completion. It SHALL NOT restart the count.

Reset
REQ-029 Reset SHALL force the state to IDLE, cnt=0, err_o=0 and stall_cnt_o=0.
REQ-030 The memory array SHALL NOT be cleared by reset.
REQ-031 A reset asserted while in WAIT SHALL drop the pending bundle; none of its writes commit.
REQ-032 With reset high, stall_o SHALL be 0 and rd_o SHALL be 0.
REQ-033 The first bundle after reset is released SHALL be handled as a fresh IDLE request.

Verification
REQ-034 LATENCY=2, write of 32'hDEADBEEF to 0x1000_0010 on port 0 with be=4'hF, then a read of the same address on port 1 in the next bundle -> stall_o high for exactly 2 cycles per bundle, rd_o[1]=32'hDEADBEEF, stall_cnt_o=4.
REQ-035 Same bundle, word 0x1000_0020 preloaded with 32'h0: port 0 writes 32'h000000AA with be=4'h1, port 1 reads 0x1000_0020 -> rd_o[1]=32'h000000AA. With the ports swapped, the reading port sees 32'h0.
REQ-036 Both ports write 0x1000_0000 with be=4'hF, data 32'h1111_1111 on port 0 and 32'h2222_2222 on port 1 -> a later read returns 32'h2222_2222.
REQ-037 Port 0 writes 0x0FFF_FFFC and port 1 reads 0x1000_1000 (DEPTH_WORDS=1024) -> err_o=2'b11 and rd_o[1]=0. err_o holds 2'b11 through later in-range bundles and clears only on reset.
REQ-038 Reset asserted in the second WAIT cycle of a write to 0x1000_0004 of 32'h5555_5555, where the word previously held 32'h1234_5678 -> a later read returns 32'h1234_5678, and stall_cnt_o=0 after reset.
REQ-039 LATENCY=0, back-to-back bundles on every cycle -> stall_o is never asserted, each read reflects all writes from earlier bundles, and stall_cnt_o stays 0.
